// File: rtl/link_scan_pkg.sv
// Shared types for the per-link bit-error scan sequencer: FSM states,
// result record layout and link index width.
package link_scan_pkg;

    localparam int LINK_W    = 4;
    localparam int MAX_LINKS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CLEAR,
        S_SETTLE,
        S_RUN,
        S_CAPTURE,
        S_REPORT,
        S_NEXT
    } scan_state_t;

    typedef struct packed {
        logic [LINK_W-1:0] link;
        logic [31:0]       errs;
        logic [31:0]       words;
        logic              fail;
        logic              timeout;
    } scan_rec_t;

endpackage

// File: rtl/link_scan_ctrl_if.sv
// Result record stream (valid/ready) between the scan sequencer and its consumer.
interface link_scan_ctrl_if;
    import link_scan_pkg::*;

    logic              res_valid;
    logic              res_ready;
    logic [LINK_W-1:0] res_link;
    logic [31:0]       res_errs;
    logic [31:0]       res_words;
    logic              res_fail;
    logic              res_timeout;

    modport master (
        output res_valid, res_link, res_errs, res_words, res_fail, res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_link, res_errs, res_words, res_fail, res_timeout,
        output res_ready
    );

endinterface

// File: rtl/link_scan_ptr.sv
// Priority encoder: lowest enabled link (first=1) or next enabled link above base.
module link_scan_ptr
    import link_scan_pkg::*;
#(
    parameter int NLINKS = 8
) (
    input  logic [NLINKS-1:0] mask,
    input  logic [LINK_W-1:0] base,
    input  logic              first,
    output logic [LINK_W-1:0] next_link,
    output logic              none_left
);

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path
        // through this block leaves a value unassigned, which would infer a latch.
        next_link = '0;
        none_left = 1'b1;
        // Descending scan: the last hit written is the lowest qualifying index.
        for (int i = NLINKS - 1; i >= 0; i--) begin
            if (mask[i] && (first || i > int'(base))) begin
                next_link = LINK_W'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/link_scan_ctrl.sv
// Walks the enabled links, runs a comparator window on each one and emits
// one pass/fail result record per link.
module link_scan_ctrl
    import link_scan_pkg::*;
#(
    parameter int NLINKS         = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NLINKS-1:0]    link_enable,
    input  logic [31:0]          window_words,
    input  logic [31:0]          err_threshold,
    output logic                 cmp_reset,
    output logic                 cmp_latch,
    output logic [MAX_LINKS-1:0] cmp_active_links,
    output logic                 cmp_active_links_map,
    input  logic [31:0]          cmp_word_count,
    input  logic [31:0]          cmp_err_count,
    link_scan_ctrl_if.master     res,
    output logic                 busy,
    output logic                 done,
    output logic [NLINKS-1:0]    fail_mask
);

    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES);
    localparam logic [31:0] TMO_LIMIT   = 32'(TIMEOUT_CYCLES);

    scan_state_t       state;
    logic [LINK_W-1:0] p;
    logic [NLINKS-1:0] en_q;
    logic [31:0]       window_q;
    logic [31:0]       thresh_q;
    logic [31:0]       settle_cnt;
    logic [31:0]       tmo_cnt;
    logic [31:0]       last_words;
    scan_rec_t         rec;
    logic              res_valid_q;

    logic [NLINKS-1:0] ptr_mask;
    logic [LINK_W-1:0] nxt;
    logic              none_left;
    logic              window_hit;
    logic              tmo_hit;

    // In IDLE the encoder looks at the live enables to pick the first link.
    assign ptr_mask   = (state == S_IDLE) ? link_enable : en_q;
    assign window_hit = (cmp_word_count >= window_q);
    assign tmo_hit    = (tmo_cnt == TMO_LIMIT);

    link_scan_ptr #(.NLINKS(NLINKS)) u_ptr (
        .mask      (ptr_mask),
        .base      (p),
        .first     (state == S_IDLE),
        .next_link (nxt),
        .none_left (none_left)
    );

    assign cmp_active_links_map = 1'b1;

    assign res.res_valid   = res_valid_q;
    assign res.res_link    = rec.link;
    assign res.res_errs    = rec.errs;
    assign res.res_words   = rec.words;
    assign res.res_fail    = rec.fail;
    assign res.res_timeout = rec.timeout;

    // NOTE: all state below is updated with non-blocking assignments, so every
    // branch reads the values from before this edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state            <= S_IDLE;
            p                <= '0;
            en_q             <= '0;
            window_q         <= '0;
            thresh_q         <= '0;
            settle_cnt       <= '0;
            tmo_cnt          <= '0;
            last_words       <= '0;
            rec              <= '0;
            res_valid_q      <= 1'b0;
            cmp_reset        <= 1'b0;
            cmp_latch        <= 1'b0;
            cmp_active_links <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fail_mask        <= '0;
        end else if (abort) begin
            // Abandon the scan; the comparator is reset and partial fail bits kept.
            state       <= S_IDLE;
            cmp_reset   <= 1'b1;
            cmp_latch   <= 1'b0;
            res_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            cmp_reset <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        en_q      <= link_enable;
                        window_q  <= (window_words == 32'd0) ? 32'd1 : window_words;
                        thresh_q  <= err_threshold;
                        fail_mask <= '0;
                        busy      <= 1'b1;
                        if (none_left) begin
                            state <= S_NEXT;
                        end else begin
                            p                <= nxt;
                            cmp_active_links <= MAX_LINKS'(1) << nxt;
                            state            <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    cmp_reset <= 1'b1;
                    state     <= S_CLEAR;
                end
                S_CLEAR: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 32'd1;
                    if (settle_cnt == 32'd1) begin
                        tmo_cnt    <= '0;
                        last_words <= cmp_word_count;
                        cmp_latch  <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    last_words <= cmp_word_count;
                    if (cmp_word_count != last_words) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                    // A completed window wins over a coincident timeout.
                    if (window_hit || tmo_hit) begin
                        cmp_latch   <= 1'b0;
                        rec.link    <= p;
                        rec.errs    <= cmp_err_count;
                        rec.words   <= cmp_word_count;
                        rec.timeout <= !window_hit;
                        rec.fail    <= !window_hit || (cmp_err_count > thresh_q);
                        state       <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    fail_mask   <= fail_mask | ({NLINKS{rec.fail}} & cmp_active_links[NLINKS-1:0]);
                    res_valid_q <= 1'b1;
                    state       <= S_REPORT;
                end
                S_REPORT: begin
                    if (res.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (none_left) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        p                <= nxt;
                        cmp_active_links <= MAX_LINKS'(1) << nxt;
                        state            <= S_SELECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
